// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Debounces a mechanical pushbutton and produces a clean level plus strobes.
// The raw pin goes through a two-flop synchronizer and is then normalised to
// active-high. An FSM must see DEBOUNCE_CYCLES consecutive stable samples
// before it accepts a level change. All outputs are registered one stage
// after the FSM state.
//
// Optional feature: define BUTTON_DEBOUNCER_AUTOREPEAT_EN to enable
// auto-repeat. While the button is held, repeat_pulse fires REPEAT_DELAY
// cycles after press_pulse and then every REPEAT_PERIOD cycles. The port list
// is identical in both builds; without the macro, repeat_pulse is tied low.
//
// Ports:
//   clock         in   system clock, all state on the rising edge
//   reset         in   synchronous, active-high reset
//   btn_raw       in   asynchronous, bouncing pushbutton pin
//   btn_level     out  debounced level, 1 = pressed
//   press_pulse   out  one-cycle strobe on an accepted press
//   release_pulse out  one-cycle strobe on an accepted release
//   repeat_pulse  out  one-cycle strobe per auto-repeat tick
//   step          out  press_pulse | repeat_pulse (downstream counter enable)
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned BTN_ACTIVE_LOW  = 1,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step
);

    localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CYC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);

    // Comparing against N-1 on the current value is the "would reach N" test.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Synchronizer idle level corresponds to the released button.
    localparam logic             SYNC_IDLE = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync_active;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Normalisation happens only after the second synchronizer flop.
    assign sync_active = sync2_q ^ SYNC_IDLE;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        // A disagreeing sample always wins over the counter reaching its limit.
        unique case (state_q)
            RELEASED: begin
                if (sync_active) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_PEND: begin
                if (!sync_active) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                if (!sync_active) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_PEND: begin
                if (sync_active) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        // Output stage follows state_q. The registered level of the previous
        // cycle identifies the entry cycle into PRESSED or RELEASED, so a
        // PRESSED<->RELEASE_PEND bounce produces no strobe.
        btn_level_d = (state_q == PRESSED) || (state_q == RELEASE_PEND);
        press_d     = (state_q == PRESSED) && !btn_level_q;
        release_d   = (state_q == RELEASED) && btn_level_q;
    end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;   // first repeat already issued
    logic             repeat_q, repeat_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] rpt_target;

    always_comb begin
        rpt_target  = rpt_armed_q ? PERIOD_LAST : DELAY_LAST;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        repeat_d    = 1'b0;

        if (state_q == PRESSED) begin
            if (!btn_level_q) begin
                // Entry cycle, the one that emits press_pulse: restart the timer.
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b0;
            end else if (rpt_cnt_q == rpt_target) begin
                repeat_d    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = sat_inc(rpt_cnt_q);
            end
        end else if (state_q != RELEASE_PEND) begin
            // RELEASE_PEND holds the timer so that a release bounce only pauses it.
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end

        step_d = press_d | repeat_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
            repeat_q    <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
            repeat_q    <= repeat_d;
            step_q      <= step_d;
        end
    end

    assign repeat_pulse = repeat_q;
    assign step         = step_q;
`else
    assign repeat_pulse = 1'b0;
    assign step         = press_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= SYNC_IDLE;
            sync2_q     <= SYNC_IDLE;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Drives button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, BTN_ACTIVE_LOW=1. Each vector sets reset/btn_raw before one
// rising edge. Its expected outputs after that edge go into a scoreboard queue
// and are popped and compared 1 ns after the edge.
// Edge numbering: the first edge that samples a new raw level is edge 0, and
// the strobe appears after edge DEBOUNCE_CYCLES+2 = 6.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int unsigned DEB    = 4;
    localparam int unsigned DELAY  = 10;
    localparam int unsigned PERIOD = 3;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b1;
    logic btn_level, press_pulse, release_pulse, repeat_pulse, step;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .BTN_ACTIVE_LOW (1),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .step         (step)
    );

    // Expected output bits: {btn_level, press, release, repeat, step}
    typedef struct {
        logic  rst;
        logic  raw;
        int    n;
        logic  lvl;
        logic  pr;
        logic  rl;
        string tag;
    } vec_t;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic r, input logic raw, input int n,
                                input logic lvl, input logic pr, input logic rl,
                                input string tag);
        vec_t v;
        v.rst = r; v.raw = raw; v.n = n;
        v.lvl = lvl; v.pr = pr; v.rl = rl; v.tag = tag;
        vecs.push_back(v);
    endfunction

    task automatic check_out();
        sb_t        e;
        logic [4:0] act;
        act = {btn_level, press_pulse, release_pulse, repeat_pulse, step};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%b", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s t=%0t {lvl,pr,rl,rp,step} got=%b want=%b",
                         e.tag, $time, act, e.exp);
            end
        end
        checks++;
        if ((press_pulse & release_pulse) !== 1'b0) begin
            errors++;
            $display("FAIL press_and_release t=%0t got=%b%b want=no overlap",
                     $time, press_pulse, release_pulse);
        end
        checks++;
        if ((press_pulse & repeat_pulse) !== 1'b0) begin
            errors++;
            $display("FAIL press_and_repeat t=%0t got=%b%b want=no overlap",
                     $time, press_pulse, repeat_pulse);
        end
    endtask

    task automatic apply_vec(input logic r, input logic raw,
                             input logic [4:0] exp, input string tag);
        sb_t e;
        @(negedge clk);
        reset   = r;
        btn_raw = raw;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic rp;

        // ------------------------------------------------------------------
        // Vector table: rst, raw, count, btn_level, press, release, tag
        // ------------------------------------------------------------------
        add(1, 1, 2, 0, 0, 0, "reset");
        add(0, 1, 3, 0, 0, 0, "idle");
        // Clean press: strobe after edge 6 only
        add(0, 0, 6, 0, 0, 0, "press_wait");
        add(0, 0, 1, 1, 1, 0, "press_edge");
        add(0, 0, 4, 1, 0, 0, "pressed");
        // Clean release
        add(0, 1, 6, 1, 0, 0, "rel_wait");
        add(0, 1, 1, 0, 0, 1, "rel_edge");
        add(0, 1, 2, 0, 0, 0, "released");
        // 3-cycle press bounce: counter reaches DEB-1 and then falls back
        add(0, 0, 3, 0, 0, 0, "bounce_lo");
        add(0, 1, 6, 0, 0, 0, "bounce_hi");
        add(0, 0, 6, 0, 0, 0, "press2_wait");
        add(0, 0, 1, 1, 1, 0, "press2_edge");
        add(0, 0, 2, 1, 0, 0, "pressed2");
        // 3-cycle release bounce while held: level stays, no strobes
        add(0, 1, 3, 1, 0, 0, "rbounce_hi");
        add(0, 0, 3, 1, 0, 0, "rbounce_lo");
        add(0, 1, 6, 1, 0, 0, "rel2_wait");
        add(0, 1, 1, 0, 0, 1, "rel2_edge");
        add(0, 1, 2, 0, 0, 0, "released2");
        // Reset in PRESS_PEND with counter=2, button still held
        add(0, 0, 4, 0, 0, 0, "pp_before_rst");
        add(1, 0, 1, 0, 0, 0, "rst_in_pp");
        add(0, 0, 6, 0, 0, 0, "rst_pp_wait");
        add(0, 0, 1, 1, 1, 0, "rst_pp_press");
        add(0, 0, 2, 1, 0, 0, "held3");
        // Reset while held: no release strobe, then re-debounced press
        add(1, 0, 1, 0, 0, 0, "rst_in_hold");
        add(0, 0, 6, 0, 0, 0, "rst_hold_wait");
        add(0, 0, 1, 1, 1, 0, "rst_hold_press");
        add(0, 0, 2, 1, 0, 0, "held4");
        add(0, 1, 6, 1, 0, 0, "rel4_wait");
        add(0, 1, 1, 0, 0, 1, "rel4_edge");
        add(0, 1, 3, 0, 0, 0, "idle2");

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                apply_vec(vecs[i].rst, vecs[i].raw,
                          {vecs[i].lvl, vecs[i].pr, vecs[i].rl, 1'b0, vecs[i].pr},
                          vecs[i].tag);
            end
        end

        // ------------------------------------------------------------------
        // Auto-repeat: hold 20 cycles past press_pulse. Repeats are expected
        // at press+10, +13, +16, +19 only when the feature is built in.
        // ------------------------------------------------------------------
        for (int k = 0; k < 6; k++) apply_vec(0, 0, 5'b00000, "ar_wait");
        apply_vec(0, 0, 5'b11001, "ar_press");
        for (int k = 1; k <= 20; k++) begin
            rp = AR && (k == 10 || k == 13 || k == 16 || k == 19);
            apply_vec(0, 0, {1'b1, 1'b0, 1'b0, rp, rp}, "ar_hold");
        end
        // The timer keeps running until the FSM leaves PRESSED, so one more
        // period completes at press+22 (second vector of the release wait).
        for (int k = 0; k < 6; k++) begin
            rp = AR && (k == 1);
            apply_vec(0, 1, {1'b1, 1'b0, 1'b0, rp, rp}, "ar_rel_wait");
        end
        apply_vec(0, 1, 5'b00100, "ar_rel_edge");
        for (int k = 0; k < 4; k++) apply_vec(0, 1, 5'b00000, "ar_idle");

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, number of consecutive stable sampled cycles before accepting a level change (10 ms at 12 MHz); legal range >= 2.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1, 1 = raw button reads 0 when pressed, 0 = reads 1 when pressed.
REQ-003 Parameter REPEAT_DELAY, default 6000000, cycles from press_pulse to first repeat_pulse (0.5 s at 12 MHz); legal range >= 2.
REQ-004 Parameter REPEAT_PERIOD, default 1200000, cycles between subsequent repeat_pulses (0.1 s at 12 MHz); legal range >= 2.
REQ-005 clock  input  1  single clock, 12 MHz board clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_raw  input  1  asynchronous, bouncing pushbutton pin.
REQ-008 btn_level  output  1  debounced level, 1 = pressed.
REQ-009 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-010 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-011 repeat_pulse  output  1  one-cycle strobe per auto-repeat tick.
REQ-012 step  output  1  press_pulse OR repeat_pulse; drives a downstream counter enable.

Function
REQ-013 btn_raw SHALL pass through a two-flop synchronizer, then be normalised to active-high (sync_active) per BTN_ACTIVE_LOW; no logic before the second flop.
REQ-014 FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-015 RELEASED: sync_active=1 -> PRESS_PEND, stable counter = 1; else stay.
REQ-016 PRESS_PEND: sync_active=0 -> RELEASED, counter cleared, no pulse; else counter increments; when counter would reach DEBOUNCE_CYCLES -> PRESSED.
REQ-017 PRESSED: sync_active=0 -> RELEASE_PEND, counter = 1; else stay.
REQ-018 RELEASE_PEND: sync_active=1 -> PRESSED, counter cleared, no pulse; else increment; reaching DEBOUNCE_CYCLES -> RELEASED.
REQ-019 All outputs registered; btn_level = 1 exactly in PRESSED and RELEASE_PEND.
REQ-020 press_pulse high for exactly the one cycle following the RELEASED-side-to-PRESSED transition; release_pulse likewise on entry to RELEASED from RELEASE_PEND.
REQ-021 Latency: raw level first sampled at edge k and held stable -> btn_level/pulse visible after edge k+DEBOUNCE_CYCLES+2.
REQ-022 Stable counter width = clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1); counter SHALL saturate, never wrap.
REQ-023 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no btn_level change.
REQ-024 press_pulse, release_pulse never high in the same cycle; repeat_pulse never coincides with press_pulse.

Reset
REQ-025 reset=1 at a rising edge: synchronizer flops to inactive level, FSM to RELEASED, all counters 0, all outputs 0 on next cycle.
REQ-026 Reset mid-debounce or mid-hold SHALL emit no pulse; a button held through reset is re-debounced and yields one press_pulse DEBOUNCE_CYCLES+2 edges after reset deasserts.

Configuration
REQ-027 Macro BUTTON_DEBOUNCER_AUTOREPEAT_EN defined: while in PRESSED, repeat_pulse fires REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles until leaving PRESSED; RELEASE_PEND pauses the repeat timer, return to PRESSED resumes it.
REQ-028 Macro undefined: repeat_pulse tied 0, repeat timer absent, step = press_pulse; port list unchanged.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=1)
REQ-029 btn_raw 1->0 sampled edge 0, held -> press_pulse=1 and btn_level=1 after edge 6 only; press_pulse=0 after edge 7.
REQ-030 btn_raw low 3 cycles then high (bounce) -> btn_level stays 0, no pulses; then low 10 cycles -> exactly one press_pulse.
REQ-031 Held press then btn_raw 0->1 held -> release_pulse one cycle, btn_level 0, DEBOUNCE_CYCLES+2 edges after release.
REQ-032 reset asserted one cycle during PRESS_PEND (counter=2) -> no pulse, outputs 0; button still held -> press_pulse 6 edges after reset deasserts.
REQ-033 AUTOREPEAT_EN defined, button held 20 cycles past press_pulse -> repeat_pulse at +10, +13, +16, +19; step high at press and each repeat; undefined -> repeat_pulse constant 0.
